// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types, constants and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd8;
  localparam bcd_digit_t BCD_ADJ_VAL    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } conv_state_t;

  // A digit is legal BCD when it lies in 0..9.
  function automatic logic is_valid_bcd(input bcd_digit_t digit);
    return (digit <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle between a BCD producer and the converter.
interface bcd_to_bin_seq_if #(
  parameter int N_DIGITS = 2,
  parameter int BIN_W    = 7
);

  logic                    start;
  logic [4*N_DIGITS-1:0]   bcd_in;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [BIN_W-1:0]        bin_out;

  // The requester drives start/bcd_in and observes status and result.
  modport master (
    output start, bcd_in,
    input  busy, done, err, bin_out
  );

  // The converter consumes the request and drives status and result.
  modport slave (
    input  start, bcd_in,
    output busy, done, err, bin_out
  );

endinterface

// File: rtl/bcd_to_bin_seq_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit: after a right shift a
// digit of 8 or more has picked up a half-weight bit from the digit above,
// so 3 is removed to restore its decimal meaning.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  // Subtract 3 from digits at or above 8; the result never borrows.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_ADJ_THRESH)
      digit_out = digit_in - BCD_ADJ_VAL;
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using iterative reverse double-dabble.
// One bit moves from the BCD register into the binary register per cycle;
// BIN_W cycles complete a conversion. Invalid digits are rejected up front.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 2,
  parameter int BIN_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_to_bin_seq_if.slave   bus
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_FIN   = FIN;

  logic [1:0]           state;
  logic [BCD_W-1:0]     bcd_reg;
  logic [BIN_W-1:0]     bin_reg;
  logic [CNT_W-1:0]     cnt;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [BIN_W-1:0]     bin_out_q;

  logic                     in_valid;
  logic [BCD_W+BIN_W-1:0]   shifted;
  logic [BCD_W-1:0]         shifted_bcd;
  logic [BIN_W-1:0]         shifted_bin;
  logic [BCD_W-1:0]         adj_bcd;

  // Every digit of the incoming request must be 0..9 to be converted.
  always_comb begin
    in_valid = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!is_valid_bcd(bus.bcd_in[4*i +: 4]))
        in_valid = 1'b0;
    end
  end

  assign shifted     = {bcd_reg, bin_reg} >> 1;
  assign shifted_bcd = shifted[BCD_W+BIN_W-1:BIN_W];
  assign shifted_bin = shifted[BIN_W-1:0];

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (shifted_bcd[4*g +: 4]),
      .digit_out (adj_bcd[4*g +: 4])
    );
  end

  // Control FSM plus shift datapath; done is a single-cycle pulse in FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (!in_valid) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= S_FIN;
            end else begin
              err_q   <= 1'b0;
              bcd_reg <= bus.bcd_in;
              bin_reg <= '0;
              cnt     <= '0;
              busy_q  <= 1'b1;
              state   <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          bcd_reg <= adj_bcd;
          bin_reg <= shifted_bin;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            bin_out_q <= shifted_bin;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed table, corner sequences,
// and a sweep of every two-digit BCD value against a decimal reference.
module tb_bcd_to_bin_seq;

  localparam int N_DIGITS = 2;
  localparam int BIN_W    = 7;
  localparam int LIMIT    = 20;

  logic clk;
  logic rst_n;

  bcd_to_bin_seq_if #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bcd;
    int         exp_bin;
    int         exp_err;
    int         exp_lat;
    int         exp_busy;
  } vec_t;

  vec_t vecs[8];
  int total = 0;
  int bad   = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Issue one request and follow it to its done pulse (bounded).
  task automatic apply_stimulus(input logic [7:0] v, output int got_bin, output int got_err,
                                output int lat, output int busy_cyc, output int residue,
                                output int seen, output int done_after);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = v;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!bus.done && lat < LIMIT) begin
      busy_cyc += int'(bus.busy);
      @(negedge clk);
      lat++;
    end
    seen    = int'(bus.done);
    got_bin = int'(bus.bin_out);
    got_err = int'(bus.err);
    residue = int'(dut.bcd_reg);
    @(negedge clk);
    done_after = int'(bus.done);
  endtask

  function automatic int ref_val(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  initial begin
    int gb, ge, lat, bc, res, seen, da;
    int cyc, ndone, pulses, tdone[2], rdone[2], last_bin;
    logic [7:0] v;

    vecs[0] = '{8'h42, 42, 0, BIN_W, BIN_W};
    vecs[1] = '{8'h00,  0, 0, BIN_W, BIN_W};
    vecs[2] = '{8'h09,  9, 0, BIN_W, BIN_W};
    vecs[3] = '{8'h99, 99, 0, BIN_W, BIN_W};
    vecs[4] = '{8'h3A, 99, 1, 0, 0};
    vecs[5] = '{8'h15, 15, 0, BIN_W, BIN_W};
    vecs[6] = '{8'hA0, 15, 1, 0, 0};
    vecs[7] = '{8'h80, 80, 0, BIN_W, BIN_W};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = 8'h00;
    repeat (2) @(negedge clk);
    check_output("reset busy", int'(bus.busy), 0);
    check_output("reset done", int'(bus.done), 0);
    check_output("reset err", int'(bus.err), 0);
    check_output("reset bin_out", int'(bus.bin_out), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].bcd, gb, ge, lat, bc, res, seen, da);
      check_output($sformatf("vec%0d done seen", i), seen, 1);
      check_output($sformatf("vec%0d bin_out", i), gb, vecs[i].exp_bin);
      check_output($sformatf("vec%0d err", i), ge, vecs[i].exp_err);
      check_output($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check_output($sformatf("vec%0d busy cycles", i), bc, vecs[i].exp_busy);
      check_output($sformatf("vec%0d done width", i), da, 0);
      if (vecs[i].exp_err == 0)
        check_output($sformatf("vec%0d bcd residue", i), res, 0);
    end

    // Start during SHIFT must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd_in = 8'h27;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.bcd_in = 8'h63;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    last_bin = -1;
    for (int c = 0; c < 15; c++) begin
      if (bus.done) begin
        pulses++;
        last_bin = int'(bus.bin_out);
      end
      @(negedge clk);
    end
    check_output("ignored start pulses", pulses, 1);
    check_output("ignored start result", last_bin, 27);

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd_in = 8'h58;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midreset busy", int'(bus.busy), 0);
    check_output("midreset done", int'(bus.done), 0);
    check_output("midreset bin_out", int'(bus.bin_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      pulses += int'(bus.done);
      @(negedge clk);
    end
    check_output("midreset no done", pulses, 0);
    apply_stimulus(8'h58, gb, ge, lat, bc, res, seen, da);
    check_output("after reset bin_out", gb, 58);
    check_output("after reset err", ge, 0);

    // Start held high: back-to-back conversions BIN_W+2 apart.
    @(negedge clk);
    bus.bcd_in = 8'h10;
    bus.start = 1'b1;
    @(negedge clk);
    bus.bcd_in = 8'h11;
    cyc = 0;
    ndone = 0;
    while (ndone < 2 && cyc < 40) begin
      if (bus.done) begin
        tdone[ndone] = cyc;
        rdone[ndone] = int'(bus.bin_out);
        ndone++;
        if (ndone == 2) bus.start = 1'b0;
      end
      if (ndone < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    check_output("b2b done count", ndone, 2);
    if (ndone == 2) begin
      check_output("b2b first result", rdone[0], 10);
      check_output("b2b second result", rdone[1], 11);
      check_output("b2b spacing", tdone[1] - tdone[0], BIN_W + 2);
    end
    repeat (2) @(negedge clk);

    // Full two-digit sweep against the decimal reference.
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        v = {4'(t), 4'(u)};
        apply_stimulus(v, gb, ge, lat, bc, res, seen, da);
        check_output($sformatf("sweep %02h bin", v), gb, ref_val(v));
        check_output($sformatf("sweep %02h err", v), ge, 0);
        check_output($sformatf("sweep %02h residue", v), res, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the team's binary-to-BCD/7-segment front end.
- Accepts an N-digit packed BCD value, for example from switch banks or a keypad digit buffer.
- Produces the unsigned binary equivalent using iterative reverse double-dabble: shift right, then subtract 3 from any digit ≥ 8.
- Sits between BCD-entry logic and arithmetic or counter blocks that need plain binary.

Parameters:
- N_DIGITS, 2, number of BCD digits in bcd_in.
- BIN_W, 7, binary output width; must be ≥ ceil(log2(10^N_DIGITS)); also equals the number of shift iterations.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*N_DIGITS  packed BCD, digit 0 (units) at [3:0]; sampled on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the result (or error) is valid.
- err  output  1  high if the last accepted bcd_in had any digit > 9; holds until the next accepted start.
- bin_out  output  BIN_W  last valid conversion result; holds between conversions.

Behaviour:
- Single clock. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; busy=0; done=0; err=0; bin_out=0; internal bcd and bin shift registers=0; iteration counter=0.
- FSM states: IDLE, SHIFT, FIN.
- IDLE:
  - On an edge with start=1, check every digit of bcd_in.
  - Any digit > 9: err←1, state→FIN, bin_out unchanged.
  - Otherwise: err←0, bcd_reg←bcd_in, bin_reg←0, cnt←0, busy←1, state→SHIFT.
- SHIFT, each edge:
  - Shift {bcd_reg, bin_reg} right by 1.
  - Then, on the shifted value, every BCD digit ≥ 8 has 3 subtracted (4-bit, no borrow across digits).
  - cnt←cnt+1.
  - When cnt reaches BIN_W-1 (the BIN_W-th shift): bin_out←new bin_reg, busy←0, state→FIN.
- FIN: done=1 for exactly this one cycle; state→IDLE on the next edge.
- Latency: start accepted at edge k → done high in the cycle after edge k+BIN_W+… precisely, state FIN entered at edge k+BIN_W, so done is high between edges k+BIN_W and k+BIN_W+1. Defaults give 7 shift cycles.
- Error path latency: done high in the cycle after the accepting edge (FIN entered at edge k+1's preceding edge k).
- start while busy or in FIN: ignored, not queued.
- start held high continuously: a new conversion is accepted each time the FSM returns to IDLE, i.e. back-to-back every BIN_W+2 cycles.
- bcd_in changing during SHIFT has no effect.
- rst_n low mid-conversion: immediate return to reset values; no done pulse; bin_out cleared to 0.
- Arithmetic: digit correction uses 4-bit compare-and-subtract only. The final bcd_reg must be all zero for valid input; this is not checked in RTL but is a bench assertion.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - constant BCD_MAX_DIGIT = 9.
  - constant BCD_ADJ_THRESH = 8.
  - constant BCD_ADJ_VAL = 3.
  - function is_valid_bcd(digit).
  - FSM state enum conv_state_t {IDLE, SHIFT, FIN}.
- Sub-module bcd_digit_adjust: combinational, one 4-bit digit in, corrected digit out (subtract 3 if ≥ 8). Instantiated N_DIGITS times via generate.

Test Plan:
- Reset, then start with bcd_in=8'h42 → done after 7 shift cycles; bin_out=7'd42, err=0, busy high for exactly 7 cycles.
- bcd_in=8'h99 → bin_out=7'd99; bcd_in=8'h00 → bin_out=0; bcd_in=8'h09 → bin_out=9.
- bcd_in=8'h3A (invalid units digit) → err=1 and done one cycle after acceptance; bin_out retains previous value (99). A following valid start with 8'h15 clears err and gives bin_out=15.
- Start with 8'h27, then pulse start with 8'h63 on cycle 3 of SHIFT → second request ignored; result 27; exactly one done pulse.
- Start with 8'h58, assert rst_n=0 at shift cycle 4 → busy=0, done never pulses, bin_out=0. After release, start with 8'h58 → bin_out=58.
- start held high with 8'h10, then 8'h11 → consecutive done pulses spaced BIN_W+2 cycles apart with results 10 and 11. Exhaustive sweep of 00..99 matches the reference model.
